// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_COUNT = 8;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_CLR_FIFO = 1;
    localparam int unsigned CTRL_CLR_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a simultaneous push and pop reads the old head
// before the write lands, so a full FIFO can accept a push on a pop edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // Guard against misuse so the occupancy count can never wrap.
    assign pop_ok  = pop_i & ~empty_o & ~clear_i;
    assign push_ok = push_i & (~full_o | pop_ok) & ~clear_i;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: window decode, TXDATA/STATUS/CTRL registers,
// transmit FIFO and the serializer FSM.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        sel,
    output logic [31:0] rd,
    output logic        tx
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    logic [1:0]    off;
    logic          wr_txdata, wr_ctrl;
    logic          clr_fifo, clr_ovf;
    logic          push_req, push_ok, ovf_set, pop, start_ok;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic          enable_q, enable_d;
    logic          ovf_q, ovf_d;

    tx_state_t     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          baud_done;

    logic          unused_bits;
    assign unused_bits = ^{wd[31:8], a[1:0]};

    assign sel       = (a[31:4] == BASE_ADDR[31:4]);
    assign off       = a[3:2];
    assign wr_txdata = we & sel & (off == OFF_TXDATA);
    assign wr_ctrl   = we & sel & (off == OFF_CTRL);
    assign clr_fifo  = wr_ctrl & wd[CTRL_CLR_FIFO];
    assign clr_ovf   = wr_ctrl & wd[CTRL_CLR_OVF];

    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

    // A clear on the same edge suppresses the pop so no byte escapes the flush.
    assign start_ok = enable_q & ~fifo_empty & ~clr_fifo;
    assign pop      = start_ok & ((state_q == IDLE) | ((state_q == STOP) & baud_done));

    assign push_req = wr_txdata & ~clr_fifo;
    assign push_ok  = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .clear_i (clr_fifo),
        .din_i   (wd[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        enable_d = wr_ctrl ? wd[CTRL_EN] : enable_q;
        ovf_d    = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q <= baud_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        state_q <= START;
                        shift_q <= fifo_dout;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            state_q <= START;
                            shift_q <= fifo_dout;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx = tx_q;

    always_comb begin
        rd = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    rd[STAT_FULL]       = fifo_full;
                    rd[STAT_EMPTY]      = fifo_empty;
                    rd[STAT_BUSY]       = (state_q != IDLE);
                    rd[STAT_OVF]        = ovf_q;
                    rd[STAT_COUNT +: CW] = fifo_count;
                end
                OFF_CTRL: rd[CTRL_EN] = enable_q;
                default:  rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-and-frame-timer model checked every cycle, plus literal checks.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = 32'h104;
    logic [31:0] wd = '0;
    logic        sel, tx;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_0100),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .sel   (sel),
        .rd    (rd),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // Model state: FIFO contents as a queue, and the current frame as a byte plus a cycle index.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_en = 1'b1;
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = '0;
    int         m_frames = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        logic [31:0] s;
        s = '0;
        if (addr[31:4] != 28'h000_0010) return s;
        if (addr[3:2] == 2'd1) begin
            s[0]     = (mq.size() == DEPTH);
            s[1]     = (mq.size() == 0);
            s[2]     = m_active;
            s[3]     = m_ovf;
            s[8 +: 3] = 3'(mq.size());
        end else if (addr[3:2] == 2'd2) begin
            s[0] = m_en;
        end
        return s;
    endfunction

    // Model update at each clock edge (or reset assertion).
    bit         s_sel, s_clr, s_clro, s_push, s_full, s_empty, s_fend, s_start;
    logic [1:0] s_off;
    logic [7:0] s_pop;
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_ovf    = 1'b0;
                m_en     = 1'b1;
                m_active = 1'b0;
                m_t      = 0;
            end else begin
                s_sel   = (a[31:4] == 28'h000_0010);
                s_off   = a[3:2];
                s_full  = (mq.size() == DEPTH);
                s_empty = (mq.size() == 0);
                s_clr   = we && s_sel && s_off == 2'd2 && wd[1];
                s_clro  = we && s_sel && s_off == 2'd2 && wd[2];
                s_push  = we && s_sel && s_off == 2'd0 && !s_clr;
                s_fend  = m_active && (m_t == FLEN - 1);
                s_start = m_en && !s_empty && !s_clr && (!m_active || s_fend);
                s_pop   = '0;
                if (s_start) s_pop = mq.pop_front();
                if (s_clro) m_ovf = 1'b0;
                if (s_push) begin
                    if (!s_full || s_start) mq.push_back(wd[7:0]);
                    else m_ovf = 1'b1;
                end
                if (s_clr) mq.delete();
                if (we && s_sel && s_off == 2'd2) m_en = wd[0];
                if (s_start) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    m_cur    = s_pop;
                    m_frames++;
                end else if (m_active) begin
                    if (s_fend) m_active = 1'b0;
                    else m_t++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("tx", tx, exp_tx());
            check("sel", sel, a[31:4] == 28'h000_0010);
            check("rd", rd, exp_rd(a));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        #1;
        we = 1'b1;
        a = addr;
        wd = data;
    endtask

    task automatic rdsel(input logic [31:0] addr);
        @(negedge clk);
        #1;
        we = 1'b0;
        a = addr;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active || mq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 2000, 1'b1);
    endtask

    logic [39:0] cap;
    int          f0, n;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_status", rd, 32'h0000_0002);
        #1 a = 32'h108;
        #1 check("rst_ctrl", rd, 32'h0000_0001);
        @(negedge clk);
        #1 reset = 1'b0;
        a = 32'h104;

        // Single byte 0x55
        wr(32'h100, 32'h55);
        rdsel(32'h104);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout", n < 20, 1'b1);
        cap = '0;
        cap[39] = tx;
        for (int i = 38; i >= 0; i--) begin
            @(negedge clk);
            cap[i] = tx;
        end
        check("frame_55", cap, 40'h0F0F0F0F0F);
        check("busy_last_bit", rd[2], 1'b1);
        @(negedge clk);
        check("busy_cleared", rd, 32'h0000_0002);

        // Back-to-back frames
        wr(32'h100, 32'hA1);
        wr(32'h100, 32'hB2);
        wr(32'h100, 32'hC3);
        rdsel(32'h104);
        @(negedge clk);
        check("b2b_count2", rd, 32'h0000_0204);
        repeat (40) @(negedge clk);
        check("b2b_count1", rd, 32'h0000_0104);
        repeat (40) @(negedge clk);
        check("b2b_count0", rd, 32'h0000_0006);
        wait_idle();

        // Overflow
        f0 = m_frames;
        for (int i = 0; i < 6; i++) wr(32'h100, 32'h11 + i);
        rdsel(32'h104);
        @(negedge clk);
        check("ovf_status", rd, 32'h0000_040D);
        wr(32'h108, 32'h5);
        rdsel(32'h104);
        @(negedge clk);
        check("ovf_cleared", rd, 32'h0000_0405);
        wait_idle();
        check("ovf_frames", m_frames - f0, 5);

        // Full FIFO with a push on the pop edge
        for (int i = 0; i < 5; i++) wr(32'h100, 32'h21 + i);
        rdsel(32'h104);
        @(negedge clk);
        check("full_before", rd, 32'h0000_0405);
        n = 0;
        while (!(m_active && m_t == FLEN - 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("popedge_timeout", n < 100, 1'b1);
        #1;
        we = 1'b1;
        a = 32'h100;
        wd = 32'h99;
        rdsel(32'h104);
        @(negedge clk);
        check("full_simpop", rd, 32'h0000_0405);
        wait_idle();

        // Disable mid-frame, then clear
        wr(32'h100, 32'h3C);
        wr(32'h100, 32'h4D);
        rdsel(32'h104);
        repeat (10) @(negedge clk);
        wr(32'h108, 32'h0);
        rdsel(32'h104);
        n = 0;
        while (m_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("disable_timeout", n < 100, 1'b1);
        check("disabled_held", rd, 32'h0000_0100);
        repeat (20) @(negedge clk);
        check("disabled_still", rd, 32'h0000_0100);
        wr(32'h108, 32'h2);
        rdsel(32'h104);
        @(negedge clk);
        check("cleared_status", rd, 32'h0000_0002);
        #1 a = 32'h108;
        #1 check("ctrl_disabled", rd, 32'h0000_0000);
        wr(32'h108, 32'h1);
        rdsel(32'h104);
        repeat (3) @(negedge clk);
        check("reenabled_idle", rd, 32'h0000_0002);

        // Reset mid-DATA
        wr(32'h100, 32'hF0);
        rdsel(32'h104);
        repeat (12) @(negedge clk);
        check("pre_reset_busy", rd[2], 1'b1);
        #1 reset = 1'b1;
        #1;
        check("reset_tx_async", tx, 1'b1);
        check("reset_status", rd, 32'h0000_0002);
        @(negedge clk);
        #1 a = 32'h108;
        #1 check("reset_ctrl", rd, 32'h0000_0001);
        a = 32'h10C;
        #1 check("reserved_rd", rd, 32'h0000_0000);
        a = 32'h110;
        #1;
        check("sel_outside", sel, 1'b0);
        check("rd_outside", rd, 32'h0000_0000);
        @(negedge clk);
        #1 reset = 1'b0;
        a = 32'h104;
        repeat (3) @(negedge clk);
        check("post_reset_status", rd, 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle ARM core's data port, alongside data memory. It decodes a 16-byte address window, accepts byte stores into a transmit FIFO, and serializes them as 8N1 frames on `tx`. Status and control registers are readable in the same window. The top level uses `sel` to choose between this block's `rd` and data-memory read data.

## Interface
- `BASE_ADDR`, 32'h0000_0100: window base; must be 16-byte aligned; lies outside the 64-word data RAM.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `we`, input, 1: core store strobe (MemWrite).
- `a`, input, 32: core data address (DataAdr).
- `wd`, input, 32: core store data (WriteData).
- `sel`, output, 1: combinational; `a[31:4] == BASE_ADDR[31:4]`.
- `rd`, output, 32: combinational read data; 0 when `sel` = 0.
- `tx`, output, 1: serial line, idle high, registered.

## Operation
- Register offsets come from `a[3:2]`:
  - 0, TXDATA. A write pushes `wd[7:0]`. Reads return 0.
  - 1, STATUS, read-only:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[8+:CW] FIFO count, where CW = $clog2(FIFO_DEPTH)+1.
  - 2, CTRL:
    - bit0 enable. Read/write, reset value 1.
    - bit1 clear FIFO. Write-1 pulse; reads 0.
    - bit2 clear overflow. Write-1 pulse; reads 0.
  - 3, reserved. Reads 0; writes ignored.
- A push occurs when `we & sel & off==0`. It is accepted if not full, or if a pop occurs on the same edge; otherwise the byte is dropped and overflow sets.
- FSM states are IDLE, START, DATA, STOP. Each state holds for CLKS_PER_BIT cycles, timed by a baud counter that resets on every state entry.
- IDLE → START when enable & !empty. The pop and shift-register load happen on that edge.
- START drives `tx` = 0.
- DATA drives `tx` = shift[0], LSB first, for 8 bit times. A 3-bit bit index wraps 7 → STOP.
- STOP drives `tx` = 1. At the end of STOP:
  - → START when enable & !empty (back-to-back, no idle gap, pop on that edge).
  - → IDLE otherwise.
- Clear FIFO resets the pointers and count. It does not abort an in-flight frame. If a push coincides with a clear, the clear wins and the push is discarded without setting overflow.
- Deasserting enable mid-frame lets the current frame finish; no further pops occur.
- Reset: `tx` = 1, FSM IDLE, FIFO empty, overflow 0, enable 1, counters 0. `tx` goes high immediately, even mid-frame.

## Timing
- Push at edge N with the FIFO empty and FSM IDLE: pop at edge N+1. `tx` falls after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles from `tx` falling.
- STATUS reflects register state, so a push is visible in `rd` the cycle after its edge.
- Full/empty and count are evaluated before the edge and update after it.
- A simultaneous push and pop leaves count unchanged, including when the FIFO is full.
- `sel` and `rd` have no added latency; they meet the core's single-cycle load path.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - offset constants `OFF_TXDATA`, `OFF_STATUS`, `OFF_CTRL`
  - STATUS and CTRL bit-position constants
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - inputs push, pop, clear, din
  - outputs dout, full, empty, count
  - read-before-write on simultaneous push and pop
- Top of the block: address decode, control registers, baud counter, bit counter, shift register, FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x100.
- Single byte: store 0x55 to 0x100.
  - `tx` reads 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles).
  - busy clears 40 cycles after `tx` falls.
- Back-to-back: store 0xA1, 0xB2, 0xC3 on consecutive cycles.
  - Three frames with no idle gap.
  - STATUS count reads 2, then 1, then 0.
  - empty=1 after the third pop.
- Overflow: store 6 bytes on consecutive cycles.
  - The first pops immediately, bytes 2–5 fill the FIFO (full=1), and byte 6 is dropped.
  - overflow=1 until CTRL is written with 0x5.
  - Exactly 5 frames are transmitted.
- Full with simultaneous pop: with the FIFO full, store on the exact edge of the STOP→START pop.
  - The store is accepted, count stays at 4, and overflow stays 0.
- Clear/disable:
  - Write CTRL=0x0 mid-frame: the frame completes, the FIFO is held, busy→0.
  - Then write CTRL=0x2: count=0, and enable stays 0 because the write carries bit0=0.
- Reset mid-DATA:
  - `tx`=1 immediately, STATUS reads empty=1 with all other bits 0, and CTRL reads 0x1.
  - A reserved-offset read (0x10C) returns 0, and `sel`=0 at address 0x110.
